mem_stage: RTL

Memory-access pipeline stage sitting directly downstream of the address-generate/execute stage and upstream of write-back. It consumes the execute latch fields, issues loads and stores to the data memory over a req/ack handshake, and stalls the front of the pipeline while an access is outstanding. It aligns and extends load data and forwards the destination register and value to decode. It registers the result into the MEM latch consumed by write-back.

---
 rtl/mem_stage.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and write-back.
// Issues loads/stores over a req/ack handshake, stalls upstream while an
// access is outstanding, aligns/extends load data, forwards rd to decode
// and registers the MEM latch.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned
// half/word accesses instead of silently aligning them.

package mem_stage_pkg;
  localparam int unsigned IOPBITS = 5;
  typedef logic [IOPBITS-1:0] iop_t;

  localparam iop_t LB_I  = 5'd1;
  localparam iop_t LH_I  = 5'd2;
  localparam iop_t LW_I  = 5'd3;
  localparam iop_t LBU_I = 5'd4;
  localparam iop_t LHU_I = 5'd5;
  localparam iop_t SB_I  = 5'd6;
  localparam iop_t SH_I  = 5'd7;
  localparam iop_t SW_I  = 5'd8;
  localparam iop_t ADD_I = 5'd9;
  localparam iop_t XOR_I = 5'd10;
endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DBITS     = 32,
  parameter int unsigned REGNOBITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 agex_valid,
  input  iop_t                 agex_op,
  input  logic [DBITS-1:0]     agex_aluout,
  input  logic [DBITS-1:0]     agex_st_data,
  input  logic [REGNOBITS-1:0] agex_rd,
  input  logic                 agex_wr_reg,
  input  logic [DBITS-1:0]     agex_pc,
  input  logic [DBITS-1:0]     agex_inst_count,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [DBITS-1:0]     dmem_addr,
  output logic [DBITS-1:0]     dmem_wdata,
  output logic [3:0]           dmem_wstrb,
  input  logic                 dmem_ack,
  input  logic [DBITS-1:0]     dmem_rdata,
  output logic                 stall_mem,
  output logic                 fwd_wr,
  output logic                 fwd_ready,
  output logic [REGNOBITS-1:0] fwd_rd,
  output logic [DBITS-1:0]     fwd_data,
  output logic                 mem_valid,
  output logic                 mem_wr_reg,
  output logic                 mem_misalign,
  output logic [REGNOBITS-1:0] mem_rd,
  output logic [DBITS-1:0]     mem_result,
  output logic [DBITS-1:0]     mem_pc,
  output logic [DBITS-1:0]     mem_inst_count
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Hold registers for an access that was not acked in its first cycle
  iop_t                 r_op;
  logic [DBITS-1:0]     r_addr;
  logic [DBITS-1:0]     r_sdata;
  logic [REGNOBITS-1:0] r_rd;
  logic                 r_wr_reg;
  logic [DBITS-1:0]     r_pc;
  logic [DBITS-1:0]     r_ic;

  // MEM latch
  logic                 r_mem_valid;
  logic                 r_mem_wr_reg;
  logic                 r_mem_misalign;
  logic [REGNOBITS-1:0] r_mem_rd;
  logic [DBITS-1:0]     r_mem_result;
  logic [DBITS-1:0]     r_mem_pc;
  logic [DBITS-1:0]     r_mem_ic;

  // Current instruction: hold regs while waiting, execute latch otherwise
  logic                 w_in_wait;
  logic                 w_valid;
  iop_t                 w_op;
  logic [DBITS-1:0]     w_addr;
  logic [DBITS-1:0]     w_sdata;
  logic [REGNOBITS-1:0] w_rd;
  logic                 w_wr_reg;
  logic [DBITS-1:0]     w_pc;
  logic [DBITS-1:0]     w_ic;

  logic                 w_is_load;
  logic                 w_is_store;
  logic                 w_is_half;
  logic                 w_is_word;
  logic                 w_misalign;
  logic                 w_access;
  logic                 w_stall;
  logic                 w_complete;
  logic                 w_capture;
  logic                 w_wr_eff;
  logic [1:0]           w_off;
  logic [3:0]           w_wstrb;
  logic [DBITS-1:0]     w_wdata;
  logic [DBITS-1:0]     w_shifted;
  logic [DBITS-1:0]     w_result;

  assign w_in_wait = (r_state == S_WAIT);
  assign w_valid   = w_in_wait | agex_valid;
  assign w_op      = w_in_wait ? r_op     : agex_op;
  assign w_addr    = w_in_wait ? r_addr   : agex_aluout;
  assign w_sdata   = w_in_wait ? r_sdata  : agex_st_data;
  assign w_rd      = w_in_wait ? r_rd     : agex_rd;
  assign w_wr_reg  = w_in_wait ? r_wr_reg : agex_wr_reg;
  assign w_pc      = w_in_wait ? r_pc     : agex_pc;
  assign w_ic      = w_in_wait ? r_ic     : agex_inst_count;

  assign w_is_load  = (w_op == LB_I) | (w_op == LH_I) | (w_op == LW_I) |
                      (w_op == LBU_I) | (w_op == LHU_I);
  assign w_is_store = (w_op == SB_I) | (w_op == SH_I) | (w_op == SW_I);
  assign w_is_half  = (w_op == LH_I) | (w_op == LHU_I) | (w_op == SH_I);
  assign w_is_word  = (w_op == LW_I) | (w_op == SW_I);

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misalign = w_valid & ((w_is_half & w_addr[0]) |
                                 (w_is_word & (|w_addr[1:0])));
`else
  assign w_misalign = 1'b0;
`endif

  // Handshake, stall and completion; reset suppresses any request
  assign w_access   = ~reset & w_valid & (w_is_load | w_is_store) & ~w_misalign;
  assign w_stall    = w_access & ~dmem_ack;
  assign w_complete = ~reset & w_valid & ~w_stall;
  assign w_capture  = ~w_in_wait & w_stall;
  assign w_wr_eff   = w_wr_reg & ~w_is_store & ~w_misalign;

  // Effective byte offset after size alignment
  always_comb begin
    w_off = w_addr[1:0];
    if (w_is_half) begin
      w_off = {w_addr[1], 1'b0};
    end else if (w_is_word) begin
      w_off = 2'b00;
    end
  end

  // Store byte enables and lane-replicated write data
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = '0;
    if (w_op == SB_I) begin
      w_wstrb = 4'b0001 << w_off;
      w_wdata = {(DBITS/8){w_sdata[7:0]}};
    end else if (w_op == SH_I) begin
      w_wstrb = 4'b0011 << w_off;
      w_wdata = {(DBITS/16){w_sdata[15:0]}};
    end else if (w_op == SW_I) begin
      w_wstrb = 4'b1111;
      w_wdata = w_sdata;
    end
  end

  assign w_shifted = dmem_rdata >> {w_off, 3'b000};

  // Load alignment/extension; non-loads pass the ALU result
  always_comb begin
    w_result = w_addr;
    unique case (w_op)
      LB_I:    w_result = {{(DBITS-8){w_shifted[7]}}, w_shifted[7:0]};
      LBU_I:   w_result = {{(DBITS-8){1'b0}}, w_shifted[7:0]};
      LH_I:    w_result = {{(DBITS-16){w_shifted[15]}}, w_shifted[15:0]};
      LHU_I:   w_result = {{(DBITS-16){1'b0}}, w_shifted[15:0]};
      LW_I:    w_result = dmem_rdata;
      default: w_result = w_addr;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: wait until the outstanding access is acked
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_stall)  w_state_nxt = S_WAIT;
      S_WAIT:  if (dmem_ack) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Capture the execute latch when an access must wait
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= '0;
      r_addr   <= '0;
      r_sdata  <= '0;
      r_rd     <= '0;
      r_wr_reg <= 1'b0;
      r_pc     <= '0;
      r_ic     <= '0;
    end else if (w_capture) begin
      r_op     <= agex_op;
      r_addr   <= agex_aluout;
      r_sdata  <= agex_st_data;
      r_rd     <= agex_rd;
      r_wr_reg <= agex_wr_reg;
      r_pc     <= agex_pc;
      r_ic     <= agex_inst_count;
    end
  end

  // MEM latch: results on completion, bubble otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_valid    <= 1'b0;
      r_mem_wr_reg   <= 1'b0;
      r_mem_misalign <= 1'b0;
      r_mem_rd       <= '0;
      r_mem_result   <= '0;
      r_mem_pc       <= '0;
      r_mem_ic       <= '0;
    end else begin
      r_mem_valid <= w_complete;
      if (w_complete) begin
        r_mem_wr_reg   <= w_wr_eff;
        r_mem_misalign <= w_misalign;
        r_mem_rd       <= w_rd;
        r_mem_result   <= w_result;
        r_mem_pc       <= w_pc;
        r_mem_ic       <= w_ic;
      end
    end
  end

  assign dmem_req   = w_access;
  assign dmem_we    = w_is_store;
  assign dmem_addr  = {w_addr[DBITS-1:2], 2'b00};
  assign dmem_wdata = w_wdata;
  assign dmem_wstrb = w_wstrb;
  assign stall_mem  = w_stall;

  assign fwd_wr     = ~reset & w_valid & w_wr_eff;
  assign fwd_rd     = w_rd;
  assign fwd_ready  = ~(w_access & w_is_load) | dmem_ack;
  assign fwd_data   = w_result;

  assign mem_valid      = r_mem_valid;
  assign mem_wr_reg     = r_mem_wr_reg;
  assign mem_misalign   = r_mem_misalign;
  assign mem_rd         = r_mem_rd;
  assign mem_result     = r_mem_result;
  assign mem_pc         = r_mem_pc;
  assign mem_inst_count = r_mem_ic;

endmodule
